// File: rtl/ex_stage_pkg.sv
// Shared bus widths, R-type funct codes and the HI/LO pair type for the ID and EX stages.
package ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int FUNCT_W    = 6;
  localparam int SHAMT_W    = 5;
  localparam int REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [FUNCT_W-1:0]    funct_t;
  typedef logic [SHAMT_W-1:0]    shamt_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    data_t hi;
    data_t lo;
  } hilo_t;

  localparam funct_t FUNCT_SLL   = 6'h00;
  localparam funct_t FUNCT_SRL   = 6'h02;
  localparam funct_t FUNCT_SRA   = 6'h03;
  localparam funct_t FUNCT_SLLV  = 6'h04;
  localparam funct_t FUNCT_SRLV  = 6'h06;
  localparam funct_t FUNCT_SRAV  = 6'h07;
  localparam funct_t FUNCT_MFHI  = 6'h10;
  localparam funct_t FUNCT_MTHI  = 6'h11;
  localparam funct_t FUNCT_MFLO  = 6'h12;
  localparam funct_t FUNCT_MTLO  = 6'h13;
  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1A;
  localparam funct_t FUNCT_DIVU  = 6'h1B;
  localparam funct_t FUNCT_ADD   = 6'h20;
  localparam funct_t FUNCT_ADDU  = 6'h21;
  localparam funct_t FUNCT_SUB   = 6'h22;
  localparam funct_t FUNCT_SUBU  = 6'h23;
  localparam funct_t FUNCT_AND   = 6'h24;
  localparam funct_t FUNCT_OR    = 6'h25;
  localparam funct_t FUNCT_XOR   = 6'h26;
  localparam funct_t FUNCT_NOR   = 6'h27;
  localparam funct_t FUNCT_SLT   = 6'h2A;
  localparam funct_t FUNCT_SLTU  = 6'h2B;

  function automatic logic is_known_funct(funct_t f);
    case (f)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV,
      FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
      FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
      FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
      FUNCT_SLT, FUNCT_SLTU: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX bundle into the execute stage and the EX/MEM-bound results coming out of it.
interface ex_stage_if;
  import ex_stage_pkg::*;

  funct_t    funct_in;
  shamt_t    shamt_in;
  data_t     operand_1_in;
  data_t     operand_2_in;
  logic      write_reg_en_in;
  reg_addr_t write_reg_addr_in;
  data_t     result_out;
  logic      write_reg_en_out;
  reg_addr_t write_reg_addr_out;
  logic      stall_request_out;

  modport master (
    output funct_in, shamt_in, operand_1_in, operand_2_in,
           write_reg_en_in, write_reg_addr_in,
    input  result_out, write_reg_en_out, write_reg_addr_out, stall_request_out
  );

  modport slave (
    input  funct_in, shamt_in, operand_1_in, operand_2_in,
           write_reg_en_in, write_reg_addr_in,
    output result_out, write_reg_en_out, write_reg_addr_out, stall_request_out
  );
endinterface

// File: rtl/ex_stage_divider.sv
// Iterative restoring divider: one quotient bit per cycle over 32 BUSY cycles, then one DONE cycle.
module ex_stage_divider
  import ex_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  logic  is_signed,
  input  data_t dividend,
  input  data_t divisor,
  output logic  busy,
  output logic  done,
  output data_t quotient,
  output data_t remainder
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg;
  logic [4:0]  count_reg;
  data_t       quo_reg, rem_reg, divisor_reg;
  logic        neg_q_reg, neg_r_reg;

  logic        sign_a, sign_b;
  data_t       dividend_mag, divisor_mag, quo_next, rem_next;
  logic [DATA_W:0] rem_shift, diff;

  assign sign_a       = is_signed & dividend[DATA_W-1];
  assign sign_b       = is_signed & divisor[DATA_W-1];
  assign dividend_mag = sign_a ? -dividend : dividend;
  assign divisor_mag  = sign_b ? -divisor  : divisor;

  // quo_reg starts as the dividend and shifts its MSB into the partial remainder
  always_comb begin
    rem_shift = {rem_reg, quo_reg[DATA_W-1]};
    diff      = rem_shift - {1'b0, divisor_reg};
    if (!diff[DATA_W]) begin
      rem_next = diff[DATA_W-1:0];
      quo_next = {quo_reg[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[DATA_W-1:0];
      quo_next = {quo_reg[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            quo_reg     <= dividend_mag;
            rem_reg     <= '0;
            divisor_reg <= divisor_mag;
            neg_q_reg   <= sign_a ^ sign_b;
            neg_r_reg   <= sign_a;
            count_reg   <= '0;
            busy        <= 1'b1;
            state_reg   <= BUSY;
          end
        end
        BUSY: begin
          quo_reg   <= quo_next;
          rem_reg   <= rem_next;
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= neg_q_reg ? -quo_next : quo_next;
            remainder <= neg_r_reg ? -rem_next : rem_next;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, HI/LO registers and divide stall logic.
// Define EX_DIV_EN to build in the iterative divider; otherwise DIV/DIVU are no-ops.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ex_stage_if.slave bus
);
  funct_t funct;
  shamt_t shamt;
  data_t  op1, op2, result;
  logic   ovf, known, stall, mul_signed;
  logic [2*DATA_W-1:0] mul_a, mul_b, product;
  hilo_t  hilo_reg;
  logic   div_done;
  data_t  div_quotient, div_remainder;

  assign funct = bus.funct_in;
  assign shamt = bus.shamt_in;
  assign op1   = bus.operand_1_in;
  assign op2   = bus.operand_2_in;

  // One 64x64 multiplier serves both MULT and MULTU; the low 64 bits are exact either way
  assign mul_signed = (funct == FUNCT_MULT);
  assign mul_a      = {{DATA_W{mul_signed & op1[DATA_W-1]}}, op1};
  assign mul_b      = {{DATA_W{mul_signed & op2[DATA_W-1]}}, op2};
  assign product    = mul_a * mul_b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (funct)
      FUNCT_ADD: begin
        result = op1 + op2;
        ovf    = (op1[DATA_W-1] == op2[DATA_W-1]) && (result[DATA_W-1] != op1[DATA_W-1]);
      end
      FUNCT_ADDU: result = op1 + op2;
      FUNCT_SUB: begin
        result = op1 - op2;
        ovf    = (op1[DATA_W-1] != op2[DATA_W-1]) && (result[DATA_W-1] != op1[DATA_W-1]);
      end
      FUNCT_SUBU: result = op1 - op2;
      FUNCT_AND:  result = op1 & op2;
      FUNCT_OR:   result = op1 | op2;
      FUNCT_XOR:  result = op1 ^ op2;
      FUNCT_NOR:  result = ~(op1 | op2);
      FUNCT_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(op1) < $signed(op2))};
      FUNCT_SLTU: result = {{(DATA_W-1){1'b0}}, (op1 < op2)};
      FUNCT_SLL:  result = op2 << shamt;
      FUNCT_SRL:  result = op2 >> shamt;
      FUNCT_SRA:  result = $signed(op2) >>> shamt;
      FUNCT_SLLV: result = op2 << op1[4:0];
      FUNCT_SRLV: result = op2 >> op1[4:0];
      FUNCT_SRAV: result = $signed(op2) >>> op1[4:0];
      FUNCT_MFHI: result = hilo_reg.hi;
      FUNCT_MFLO: result = hilo_reg.lo;
      default:    result = '0;
    endcase
  end

  assign known = is_known_funct(funct);

`ifdef EX_DIV_EN
  logic is_div, div_start, div_busy;

  assign is_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
  assign div_start = is_div && (op2 != '0);

  ex_stage_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (funct == FUNCT_DIV),
    .dividend  (op1),
    .divisor   (op2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Stall covers the accepting IDLE cycle and all BUSY cycles, never DONE or reset
  assign stall = rst & (div_busy | (div_start & ~div_done));
`else
  assign stall         = 1'b0;
  assign div_done      = 1'b0;
  assign div_quotient  = '0;
  assign div_remainder = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_reg <= '0;
    end else if (div_done) begin
      hilo_reg <= '{hi: div_remainder, lo: div_quotient};
    end else begin
      case (funct)
        FUNCT_MTHI:              hilo_reg.hi <= op1;
        FUNCT_MTLO:              hilo_reg.lo <= op1;
        FUNCT_MULT, FUNCT_MULTU: hilo_reg    <= hilo_t'(product);
        default: ;
      endcase
    end
  end

  assign bus.result_out         = result;
  assign bus.write_reg_en_out   = bus.write_reg_en_in & ~stall & ~ovf & known;
  assign bus.write_reg_addr_out = bus.write_reg_addr_in;
  assign bus.stall_request_out  = stall;

endmodule
